// File: rtl/fm_freq_bcd_packer.sv
// Converts a binary FM frequency (100 kHz units) to four BCD digits with a
// sequential double-dabble, then issues one packed write to the display register.
module fm_freq_bcd_packer #(
    parameter int                         FM_ADDR_WIDTH = 6,
    parameter logic [FM_ADDR_WIDTH-1:0]   DISP_ADDR     = 6'h08,
    parameter int                         FREQ_WIDTH    = 11,
    parameter int                         FREQ_MIN      = 640,
    parameter int                         FREQ_MAX      = 1080,
    parameter int                         CH_MAX        = 25
) (
    input  logic                     clk,
    input  logic                     RSTn,
    input  logic                     start,
    input  logic [FREQ_WIDTH-1:0]    freq_100k,
    input  logic [4:0]               channel_no,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [FM_ADDR_WIDTH-1:0] wraddr,
    output logic [31:0]              wdata,
    output logic [3:0]               wea
);

    localparam int SR_W  = 16 + FREQ_WIDTH;
    localparam int CNT_W = $clog2(FREQ_WIDTH + 1);

    localparam logic [FREQ_WIDTH-1:0] W_FREQ_MIN = FREQ_MIN[FREQ_WIDTH-1:0];
    localparam logic [FREQ_WIDTH-1:0] W_FREQ_MAX = FREQ_MAX[FREQ_WIDTH-1:0];
    localparam logic [4:0]            W_CH_MAX   = CH_MAX[4:0];
    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(FREQ_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        WRITE,
        REJECT
    } state_t;

    state_t                   r_state;
    logic [SR_W-1:0]          r_shift;
    logic [CNT_W-1:0]         r_cnt;
    logic [4:0]               r_channel;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_err;
    logic [FM_ADDR_WIDTH-1:0] r_wraddr;
    logic [31:0]              r_wdata;
    logic [3:0]               r_wea;

    state_t                   w_next_state;
    logic [SR_W-1:0]          w_next_shift;
    logic [CNT_W-1:0]         w_next_cnt;
    logic [4:0]               w_next_channel;
    logic                     w_next_busy;
    logic                     w_next_done;
    logic                     w_next_err;
    logic [FM_ADDR_WIDTH-1:0] w_next_wraddr;
    logic [31:0]              w_next_wdata;
    logic [3:0]               w_next_wea;
    logic                     w_req_legal;
    logic [SR_W-1:0]          w_dabbled;

    // One double-dabble iteration: correct each BCD nibble, then shift left.
    function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] adj;
        logic [3:0]      nib;
        adj = sr;
        for (int i = 0; i < 4; i++) begin
            nib = sr[FREQ_WIDTH + 4*i +: 4];
            if (nib >= 4'd5) begin
                nib = nib + 4'd3;
            end
            adj[FREQ_WIDTH + 4*i +: 4] = nib;
        end
        return {adj[SR_W-2:0], 1'b0};
    endfunction

    assign w_req_legal = (freq_100k >= W_FREQ_MIN) && (freq_100k <= W_FREQ_MAX) &&
                         (channel_no <= W_CH_MAX);
    assign w_dabbled   = dabble_step(r_shift);

    // Outputs are registered on the transition out of WRITE, so the write cycle
    // is also the first IDLE cycle and a held start re-triggers without a gap.
    always_comb begin
        w_next_state   = r_state;
        w_next_shift   = r_shift;
        w_next_cnt     = r_cnt;
        w_next_channel = r_channel;
        w_next_busy    = 1'b0;
        w_next_done    = 1'b0;
        w_next_err     = 1'b0;
        w_next_wraddr  = '0;
        w_next_wdata   = '0;
        w_next_wea     = 4'h0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_channel = channel_no;
                    w_next_busy    = 1'b1;
                    if (!w_req_legal) begin
                        w_next_state = REJECT;
                        w_next_done  = 1'b1;
                        w_next_err   = 1'b1;
                    end else begin
                        w_next_state = CONV;
                        w_next_shift = {16'b0, freq_100k};
                        w_next_cnt   = '0;
                    end
                end
            end
            CONV: begin
                w_next_busy  = 1'b1;
                w_next_shift = w_dabbled;
                w_next_cnt   = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_LAST) begin
                    w_next_state = WRITE;
                end
            end
            WRITE: begin
                w_next_state  = IDLE;
                w_next_busy   = 1'b1;
                w_next_done   = 1'b1;
                w_next_wea    = 4'hf;
                w_next_wraddr = DISP_ADDR;
                w_next_wdata  = {11'b0, r_shift[SR_W-1 -: 16], r_channel};
            end
            REJECT: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_channel <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_wraddr  <= '0;
            r_wdata   <= '0;
            r_wea     <= 4'h0;
        end else begin
            r_state   <= w_next_state;
            r_shift   <= w_next_shift;
            r_cnt     <= w_next_cnt;
            r_channel <= w_next_channel;
            r_busy    <= w_next_busy;
            r_done    <= w_next_done;
            r_err     <= w_next_err;
            r_wraddr  <= w_next_wraddr;
            r_wdata   <= w_next_wdata;
            r_wea     <= w_next_wea;
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign err    = r_err;
    assign wraddr = r_wraddr;
    assign wdata  = r_wdata;
    assign wea    = r_wea;

endmodule
